demux8_rr_sched: RTL and testbench

//   Round-robin scheduler that sequences a 1-to-8 demux datapath: one input stream of W-bit words.

---
 rtl/demux8_pkg.sv | 32 +++
 rtl/demux8_core.sv | 16 +
 rtl/demux8_rr_sched.sv | 85 ++++++++
 tb/tb_demux8_rr_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux8_pkg.sv
// Shared types and helpers for the 1-to-8 round-robin demux scheduler.
// Holds lane count, select width, FSM state type and the round-robin picker.
package demux8_pkg;

  localparam int NLANES = 8;
  localparam int SELW   = 3;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } demux8_state_t;

  // First enabled lane strictly after last, wrapping mod 8.
  // Returns last itself when it is the only enabled lane, or when mask is 0.
  function automatic logic [SELW-1:0] rr_pick(
    input logic [NLANES-1:0] mask,
    input logic [SELW-1:0]   last
  );
    logic [SELW-1:0] idx;
    logic            found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= NLANES; i++) begin
      idx = last + SELW'(i);
      if (!found && mask[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/demux8_core.sv
// Combinational 1-to-8 demux: routes y onto the lane chosen by sel.
// Ports: y (in), sel[2:0] (in), lanes[7:0] (out, one-hot or zero).
module demux8_core
  import demux8_pkg::*;
(
  input  logic              y,
  input  logic [SELW-1:0]   sel,
  output logic [NLANES-1:0] lanes
);

  always_comb begin
    lanes      = '0;
    lanes[sel] = y;
  end

endmodule

// File: rtl/demux8_rr_sched.sv
// Round-robin scheduler for a 1-to-8 demux with per-lane valid/ready.
// Ports: clk, rst_n (async low); in_valid/in_data/in_ready (producer);
//   cfg_mask[7:0] lane enables; out_valid[7:0], out_data, out_ready[7:0]
//   (lanes); sel[2:0] demux select; busy (word held).
// Option: DEMUX8_RR_SKIP_EN lets a stalled word hop to the next enabled lane.
module demux8_rr_sched
  import demux8_pkg::*;
#(
  parameter int              W        = 8,
  parameter logic [SELW-1:0] RST_LANE = 3'd7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  output logic              in_ready,
  input  logic [NLANES-1:0] cfg_mask,
  output logic [NLANES-1:0] out_valid,
  output logic [W-1:0]      out_data,
  input  logic [NLANES-1:0] out_ready,
  output logic [SELW-1:0]   sel,
  output logic              busy
);

  demux8_state_t   state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] last_q, last_d;
  logic [W-1:0]    data_q, data_d;

  logic            fire_in;
  logic            fire_out;
  logic [SELW-1:0] last_upd;

  always_comb begin
    busy     = (state_q == ST_FULL);
    fire_out = busy & out_ready[sel_q];
    in_ready = rst_n & (|cfg_mask) & (~busy | fire_out);
    fire_in  = in_valid & in_ready;
    // A drain in the same cycle advances the pointer before the new pick.
    last_upd = fire_out ? sel_q : last_q;

    state_d  = state_q;
    sel_d    = sel_q;
    data_d   = data_q;
    last_d   = last_upd;

    if (fire_in) begin
      state_d = ST_FULL;
      sel_d   = rr_pick(cfg_mask, last_upd);
      data_d  = in_data;
    end else if (fire_out) begin
      state_d = ST_EMPTY;
    end
`ifdef DEMUX8_RR_SKIP_EN
    else if (busy) begin
      // Valid has been up a full cycle without ready: hop one lane.
      sel_d = rr_pick(cfg_mask, sel_q);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      sel_q   <= '0;
      last_q  <= RST_LANE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  demux8_core u_core (
    .y     (busy),
    .sel   (sel_q),
    .lanes (out_valid)
  );

  assign out_data = data_q;
  assign sel      = sel_q;

endmodule

// File: tb/tb_demux8_rr_sched.sv
// Directed self-checking bench for demux8_rr_sched.
// Strict or skip expectations follow DEMUX8_RR_SKIP_EN.
module tb_demux8_rr_sched;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] cfg_mask;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [7:0] out_ready;
  logic [2:0] sel;
  logic       busy;

  int checks;
  int failures;

  demux8_rr_sched #(.W(8), .RST_LANE(3'd7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cfg_mask  (cfg_mask),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_lane(input string tag, input int lane,
                          input logic [7:0] d);
    logic [7:0] oh;
    oh = 8'h01 << lane;
    chk({tag, "_sel"}, 32'(sel), 32'(lane));
    chk({tag, "_val"}, 32'(out_valid), 32'(oh));
    chk({tag, "_dat"}, 32'(out_data), 32'(d));
  endtask

  int lanes2 [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
  int lanes3 [4]  = '{2, 5, 7, 2};

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    cfg_mask  = 8'hFF;
    out_ready = 8'hFF;
    #1;
    chk("rst_val", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_dat", 32'(out_data), 32'h0);
    chk("rst_rdy", 32'(in_ready), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Full rate: lanes 0..7,0,1 from reset pointer 7.
    in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      in_data = 8'h10 + 8'(n);
      #1;
      chk($sformatf("fr_rdy%0d", n), 32'(in_ready), 32'h1);
      tick();
      chk_lane($sformatf("fr%0d", n), lanes2[n], 8'h10 + 8'(n));
    end
    in_valid = 1'b0;
    tick();
    chk("fr_drain_busy", 32'(busy), 32'h0);
    chk("fr_drain_dat", 32'(out_data), 32'h19);
    chk("fr_drain_val", 32'(out_valid), 32'h0);

    // Masking: lanes 2,5,7,2 after last=1.
    cfg_mask = 8'b1010_0100;
    in_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      in_data = 8'h30 + 8'(n);
      tick();
      chk_lane($sformatf("mk%0d", n), lanes3[n], 8'h30 + 8'(n));
    end
    in_valid = 1'b0;
    tick();
    cfg_mask = 8'h00;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    chk("mk0_rdy", 32'(in_ready), 32'h0);
    tick();
    chk("mk0_busy", 32'(busy), 32'h0);
    in_valid = 1'b0;

`ifndef DEMUX8_RR_SKIP_EN
    // Backpressure on lane 3 (last=2).
    cfg_mask  = 8'hFF;
    out_ready = 8'hF7;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk_lane($sformatf("bp%0d", n), 3, 8'hA5);
      chk($sformatf("bp_rdy%0d", n), 32'(in_ready), 32'h0);
      tick();
    end
    out_ready = 8'hFF;
    #1;
    chk("bp_rise_rdy", 32'(in_ready), 32'h1);
    tick();
    chk("bp_done_busy", 32'(busy), 32'h0);

    // Mask change while FULL on lane 1: strict keeps lane 1.
    cfg_mask  = 8'h02;
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_data   = 8'h66;
    tick();
    in_valid = 1'b0;
    cfg_mask = 8'hFD;
    tick();
    tick();
    chk_lane("mc", 1, 8'h66);
    chk("mc_busy", 32'(busy), 32'h1);
    out_ready = 8'h02;
    tick();
    chk("mc_done_busy", 32'(busy), 32'h0);
`else
    // Skip: picked lane 3, hops 4,5,6, delivered on 6, next pick 7.
    cfg_mask  = 8'hFF;
    out_ready = 8'h40;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk_lane("sk3", 3, 8'hA5);
    tick();
    chk_lane("sk4", 4, 8'hA5);
    tick();
    chk_lane("sk5", 5, 8'hA5);
    tick();
    chk_lane("sk6", 6, 8'hA5);
    in_valid = 1'b1;
    in_data  = 8'hB6;
    #1;
    chk("sk_rdy", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk_lane("sk7", 7, 8'hB6);
    out_ready = 8'hFF;
    tick();
    chk("sk_done_busy", 32'(busy), 32'h0);

    // Only enabled lane: no hop.
    cfg_mask  = 8'h02;
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_data   = 8'h66;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk_lane("one", 1, 8'h66);
    out_ready = 8'h02;
    tick();
    chk("one_done_busy", 32'(busy), 32'h0);
`endif

    // Reset mid-FULL, then first word goes to lane 0.
    cfg_mask  = 8'hFF;
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    tick();
    in_valid = 1'b0;
    chk("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mrst_val", 32'(out_valid), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_sel", 32'(sel), 32'h0);
    chk("mrst_rdy", 32'(in_ready), 32'h0);
    tick();
    rst_n     = 1'b1;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    in_data   = 8'h88;
    tick();
    in_valid = 1'b0;
    chk_lane("post", 0, 8'h88);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
